// File: rtl/fir_coef_pkg.sv
// Shared definitions for the FIR coefficient loader: FSM states,
// control-word bit positions and default geometry.
package fir_coef_pkg;

   localparam int LOAD_BIT  = 0;
   localparam int FORCE_BIT = 1;
   localparam int CLR_BIT   = 2;

   localparam int DEF_COEF_W    = 16;
   localparam int DEF_NUM_PAIRS = 12;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_WR_LO,
      ST_WR_HI,
      ST_WAIT_SYNC,
      ST_SWAP
   } state_t;

   // pair_sel width; a single pair still needs one select bit
   function automatic int sel_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rise_detect.sv
// Registers a level once and flags its 0->1 transition for one cycle.
module rise_detect (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic pulse
);

   logic q;
   logic q_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q   <= 1'b0;
         q_d <= 1'b0;
      end else begin
         q   <= d;
         q_d <= q;
      end
   end

   assign pulse = q & ~q_d;

endmodule

// File: rtl/fir_coef_loader.sv
// Copies packed coefficient pairs into the inactive bank of the FIR
// coefficient RAM, then swaps banks on the next frame boundary.
//
//   state      | meaning
//   -----------+---------------------------------------------------
//   IDLE       | waiting for a load request
//   FETCH      | pair_sel presents the current pair index
//   WR_LO      | latch pair word, write upper field to even tap
//   WR_HI      | write latched lower field to odd tap, advance
//   WAIT_SYNC  | inactive bank complete, wait for sync or force
//   SWAP       | flip active bank, count the completed load
module fir_coef_loader
   import fir_coef_pkg::*;
#(
   parameter  int NUM_PAIRS = DEF_NUM_PAIRS,
   parameter  int COEF_W    = DEF_COEF_W,
   localparam int SEL_W     = sel_w(NUM_PAIRS),
   localparam int ADDR_W    = SEL_W + 2
) (
   input  logic              user_clk,
   input  logic              user_rst_n,
   input  logic [31:0]       ctrl_in,
   output logic [SEL_W-1:0]  pair_sel,
   input  logic [31:0]       pair_data,
   input  logic              sync_in,
   output logic              coef_we,
   output logic [ADDR_W-1:0] coef_addr,
   output logic [COEF_W-1:0] coef_data,
   output logic              coef_bank,
   output logic              busy,
   output logic [15:0]       load_count,
   output logic              err_overrun
);

   state_t              state;
   logic [SEL_W-1:0]    idx;
   logic [COEF_W-1:0]   lo_q;
   logic                load_pulse;
   logic                force_q;
   logic                clr_q;
   logic                unused_ctrl;

   assign unused_ctrl = ^ctrl_in[31:CLR_BIT+1];

   rise_detect u_load_rise (
      .clk   (user_clk),
      .rst_n (user_rst_n),
      .d     (ctrl_in[LOAD_BIT]),
      .pulse (load_pulse)
   );

   always_ff @(posedge user_clk or negedge user_rst_n) begin
      if (!user_rst_n) begin
         force_q <= 1'b0;
         clr_q   <= 1'b0;
      end else begin
         force_q <= ctrl_in[FORCE_BIT];
         clr_q   <= ctrl_in[CLR_BIT];
      end
   end

   always_ff @(posedge user_clk or negedge user_rst_n) begin
      if (!user_rst_n) begin
         state       <= ST_IDLE;
         idx         <= '0;
         lo_q        <= '0;
         coef_bank   <= 1'b0;
         load_count  <= 16'd0;
         err_overrun <= 1'b0;
      end else begin
         // SWAP counts as busy, so a request there is an overrun too
         if (load_pulse && (state != ST_IDLE))
            err_overrun <= 1'b1;
         else if (clr_q)
            err_overrun <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (load_pulse) begin
                  idx   <= '0;
                  state <= ST_FETCH;
               end
            end
            ST_FETCH: state <= ST_WR_LO;
            ST_WR_LO: begin
               lo_q  <= pair_data[COEF_W-1:0];
               state <= ST_WR_HI;
            end
            ST_WR_HI: begin
               if (idx == SEL_W'(NUM_PAIRS - 1)) begin
                  state <= ST_WAIT_SYNC;
               end else begin
                  idx   <= idx + 1'b1;
                  state <= ST_FETCH;
               end
            end
            ST_WAIT_SYNC: begin
               if (sync_in || force_q)
                  state <= ST_SWAP;
            end
            ST_SWAP: begin
               coef_bank  <= ~coef_bank;
               load_count <= load_count + 16'd1;
               state      <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign pair_sel = idx;
   assign busy     = (state != ST_IDLE);

   // pair_data is only valid in WR_LO, so the write port is decoded from state
   always_comb begin
      coef_we   = 1'b0;
      coef_addr = '0;
      coef_data = '0;
      case (state)
         ST_WR_LO: begin
            coef_we   = 1'b1;
            coef_addr = {~coef_bank, idx, 1'b0};
            coef_data = pair_data[2*COEF_W-1:COEF_W];
         end
         ST_WR_HI: begin
            coef_we   = 1'b1;
            coef_addr = {~coef_bank, idx, 1'b1};
            coef_data = lo_q;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_fir_coef_loader.sv
// Directed bench for fir_coef_loader: bank loads, swaps, overrun,
// reset abort, forced swap and held load request.
module tb_fir_coef_loader;

   localparam int NP = 12;
   localparam int NT = 2 * NP;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] ctrl_in = 32'd0;
   logic [3:0]  pair_sel;
   logic [31:0] pair_data = 32'd0;
   logic        sync_in = 1'b0;
   logic        coef_we;
   logic [5:0]  coef_addr;
   logic [15:0] coef_data;
   logic        coef_bank;
   logic        busy;
   logic [15:0] load_count;
   logic        err_overrun;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int wq_addr[$];
   int wq_data[$];
   int wq_cyc[$];

   fir_coef_loader #(.NUM_PAIRS(NP), .COEF_W(16)) dut (
      .user_clk    (clk),
      .user_rst_n  (rst_n),
      .ctrl_in     (ctrl_in),
      .pair_sel    (pair_sel),
      .pair_data   (pair_data),
      .sync_in     (sync_in),
      .coef_we     (coef_we),
      .coef_addr   (coef_addr),
      .coef_data   (coef_data),
      .coef_bank   (coef_bank),
      .busy        (busy),
      .load_count  (load_count),
      .err_overrun (err_overrun)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // pair register file: pair i = {A000+2i, A001+2i}, one cycle read latency
   always @(posedge clk)
      pair_data <= {16'hA000 + {11'd0, pair_sel, 1'b0}, 16'hA001 + {11'd0, pair_sel, 1'b0}};

   always @(negedge clk) begin
      if (coef_we === 1'b1) begin
         wq_addr.push_back(int'(coef_addr));
         wq_data.push_back(int'(coef_data));
         wq_cyc.push_back(cyc);
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, want);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic clear_q();
      wq_addr.delete();
      wq_data.delete();
      wq_cyc.delete();
   endtask

   // run one load; ovr_at>=0 raises load_req once that many writes are seen
   task automatic do_load(input int base, input logic [31:0] extra,
                          input bit issue, input int ovr_at);
      int n;
      bit fired;
      clear_q();
      if (issue) begin
         ctrl_in = extra | 32'd1;
         step();
      end
      ctrl_in = extra;
      n = 0;
      fired = 0;
      while (wq_addr.size() < NT && n < 400) begin
         if (ovr_at >= 0 && !fired && wq_addr.size() == ovr_at) begin
            ctrl_in = extra | 32'd1;
            fired = 1;
         end else begin
            ctrl_in = extra;
         end
         step();
         n++;
      end
      ctrl_in = extra;
      chk("load_nwr", wq_addr.size(), NT);
      for (int j = 0; j < wq_addr.size(); j++) begin
         chk($sformatf("wr_addr[%0d]", j), wq_addr[j], base + j);
         chk($sformatf("wr_data[%0d]", j), wq_data[j], 32'hA000 + j);
      end
      if (wq_addr.size() == NT)
         chk("load_span", wq_cyc[NT-1] - wq_cyc[0], 3 * NP - 2);
   endtask

   task automatic do_swap(input logic exp_bank, input int exp_cnt);
      logic pre;
      pre = ~exp_bank;
      repeat (5) step();
      chk("wait_busy", busy, 1);
      chk("wait_bank", coef_bank, pre);
      sync_in = 1'b1;
      step();
      sync_in = 1'b0;
      chk("swap_busy", busy, 1);
      chk("swap_bank_hold", coef_bank, pre);
      step();
      chk("bank", coef_bank, exp_bank);
      chk("count", load_count, exp_cnt);
      chk("idle", busy, 0);
   endtask

   initial begin
      repeat (3) step();
      chk("rst_we", coef_we, 0);
      chk("rst_addr", coef_addr, 0);
      chk("rst_data", coef_data, 0);
      chk("rst_sel", pair_sel, 0);
      chk("rst_bank", coef_bank, 0);
      chk("rst_busy", busy, 0);
      chk("rst_count", load_count, 0);
      chk("rst_err", err_overrun, 0);
      rst_n = 1'b1;
      repeat (2) step();

      // first load into bank 1, second back into bank 0
      do_load(32, 32'd0, 1, -1);
      do_swap(1'b1, 1);
      do_load(0, 32'd0, 1, -1);
      do_swap(1'b0, 2);

      // overrun during WR_HI of pair 4, then clear
      do_load(32, 32'd0, 1, 9);
      chk("ovr_set", err_overrun, 1);
      do_swap(1'b1, 3);
      chk("ovr_sticky", err_overrun, 1);
      ctrl_in = 32'h4;
      step();
      ctrl_in = 32'h0;
      step();
      chk("ovr_clr", err_overrun, 0);

      // request landing in the SWAP cycle is an overrun, no new load
      do_load(0, 32'd0, 1, -1);
      sync_in = 1'b1;
      step();
      ctrl_in = 32'h1;
      step();
      sync_in = 1'b0;
      chk("swapreq_busy", busy, 1);
      step();
      ctrl_in = 32'h0;
      chk("swapreq_bank", coef_bank, 1'b0);
      chk("swapreq_count", load_count, 4);
      chk("swapreq_err", err_overrun, 1);
      clear_q();
      repeat (6) step();
      chk("swapreq_nwr", wq_addr.size(), 0);
      chk("swapreq_idle", busy, 0);
      ctrl_in = 32'h4;
      step();
      ctrl_in = 32'h0;
      step();
      chk("swapreq_clr", err_overrun, 0);

      // request in the first IDLE cycle after SWAP starts a load
      do_load(32, 32'd0, 1, -1);
      sync_in = 1'b1;
      step();
      step();
      sync_in = 1'b0;
      ctrl_in = 32'h1;
      step();
      ctrl_in = 32'h0;
      chk("idlereq_bank", coef_bank, 1'b1);
      chk("idlereq_count", load_count, 5);
      do_load(0, 32'd0, 0, -1);
      chk("idlereq_err", err_overrun, 0);
      do_swap(1'b0, 6);

      // reset in the middle of pair 7 aborts the load
      clear_q();
      ctrl_in = 32'h1;
      step();
      ctrl_in = 32'h0;
      for (int n = 0; n < 200 && wq_addr.size() < 15; n++) step();
      chk("abort_pre_nwr", wq_addr.size(), 15);
      rst_n = 1'b0;
      #1;
      chk("abort_we", coef_we, 0);
      chk("abort_busy", busy, 0);
      chk("abort_bank", coef_bank, 0);
      chk("abort_count", load_count, 0);
      repeat (2) step();
      rst_n = 1'b1;
      for (int k = 0; k < 40; k++) begin
         sync_in = (k % 7 == 3);
         step();
      end
      sync_in = 1'b0;
      chk("abort_post_nwr", wq_addr.size(), 15);
      chk("abort_post_bank", coef_bank, 0);
      chk("abort_post_count", load_count, 0);
      chk("abort_post_busy", busy, 0);

      // force_swap: SWAP one cycle after WAIT_SYNC entry
      do_load(32, 32'h2, 1, -1);
      step();
      chk("force_wait_busy", busy, 1);
      chk("force_wait_bank", coef_bank, 0);
      step();
      chk("force_swap_busy", busy, 1);
      chk("force_swap_bank", coef_bank, 0);
      step();
      ctrl_in = 32'h0;
      chk("force_bank", coef_bank, 1);
      chk("force_count", load_count, 1);
      chk("force_idle", busy, 0);
      for (int k = 0; k < 12; k++) begin
         sync_in = (k % 3 == 0);
         step();
      end
      sync_in = 1'b0;
      chk("idle_sync_bank", coef_bank, 1);
      chk("idle_sync_count", load_count, 1);

      // load_req held high for 100 cycles starts exactly one load
      clear_q();
      ctrl_in = 32'h1;
      for (int k = 0; k < 100; k++) begin
         sync_in = (k == 85);
         step();
      end
      sync_in = 1'b0;
      ctrl_in = 32'h0;
      repeat (3) step();
      chk("held_nwr", wq_addr.size(), NT);
      if (wq_addr.size() > 0) chk("held_first_addr", wq_addr[0], 0);
      chk("held_count", load_count, 2);
      chk("held_bank", coef_bank, 0);
      chk("held_err", err_overrun, 0);
      chk("held_idle", busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/fir_coef_loader.md
FIR_COEF_LOADER -- requirements
Module: fir_coef_loader

Interface
REQ-001 Parameter NUM_PAIRS, default 12, SHALL set the number of packed 32-bit coefficient-pair registers (taps = 2*NUM_PAIRS).
REQ-002 Parameter COEF_W, default 16, SHALL set the coefficient width; each pair word SHALL hold exactly two COEF_W fields.
REQ-003 user_clk  in  1  sole clock; all logic rising-edge.
REQ-004 user_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 ctrl_in  in  32  software control word: bit0 load_req, bit1 force_swap, bit2 clr_err.
REQ-006 pair_sel  out  clog2(NUM_PAIRS)  index of the pair register being fetched.
REQ-007 pair_data  in  32  selected pair word, valid one cycle after pair_sel changes.
REQ-008 sync_in  in  1  frame-boundary pulse from the channelizer datapath.
REQ-009 coef_we  out  1  coefficient RAM write enable.
REQ-010 coef_addr  out  1+clog2(2*NUM_PAIRS)  {bank bit, tap index}.
REQ-011 coef_data  out  COEF_W  coefficient write data.
REQ-012 coef_bank  out  1  bank currently used by the FIR.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 load_count  out  16  completed swap count.
REQ-015 err_overrun  out  1  sticky: load_req rose while busy.

Function
REQ-016 ctrl_in bits SHALL be registered once; a load request SHALL be a 0->1 transition of registered bit0.
REQ-017 States SHALL be IDLE, FETCH, WR_LO, WR_HI, WAIT_SYNC, SWAP.
REQ-018 IDLE: on load request, pair index SHALL be cleared and the next state SHALL be FETCH; otherwise IDLE.
REQ-019 FETCH: pair_sel SHALL equal the pair index; next state WR_LO unconditionally.
REQ-020 WR_LO: pair_data SHALL be latched internally; coef_we=1, coef_addr={~coef_bank, 2*idx}, coef_data=pair_data[31:16]; next WR_HI.
REQ-021 WR_HI: coef_we=1, coef_addr={~coef_bank, 2*idx+1}, coef_data=latched[15:0]; if idx=NUM_PAIRS-1 next WAIT_SYNC, else idx+1 and next FETCH.
REQ-022 One pair SHALL take exactly 3 cycles; full load 3*NUM_PAIRS cycles from FETCH entry to WAIT_SYNC entry.
REQ-023 Writes SHALL only target the inactive bank; coef_we SHALL be 0 outside WR_LO/WR_HI.
REQ-024 WAIT_SYNC: sync_in=1 or registered force_swap=1 SHALL move to SWAP; sync_in is ignored in any other state.
REQ-025 SWAP (one cycle): coef_bank SHALL toggle, load_count SHALL increment modulo 2^16, next IDLE.
REQ-026 Load request while busy SHALL be ignored and SHALL set err_overrun; registered clr_err=1 SHALL clear it, with set winning when both occur in the same cycle.
REQ-027 Load request seen in the SWAP cycle SHALL count as busy (overrun); a request in the first IDLE cycle after SWAP SHALL start a new load.
REQ-028 load_req held high SHALL start only one load.

Reset
REQ-029 While user_rst_n=0: state IDLE, idx 0, pair_sel 0, coef_we 0, coef_addr 0, coef_data 0, coef_bank 0, busy 0, load_count 0, err_overrun 0, ctrl registers 0.
REQ-030 Reset mid-load SHALL abort immediately with no further writes; the partially written bank SHALL NOT be swapped in.

Structure
REQ-031 Shared package fir_coef_pkg SHALL hold the state enum, ctrl bit positions (LOAD_BIT=0, FORCE_BIT=1, CLR_BIT=2) and default COEF_W/NUM_PAIRS.
REQ-032 One sub-module rise_detect (register plus 0->1 pulse) SHALL serve load_req; all else flat.

Verification
REQ-033 Pairs i loaded with {16'hA000+2i, 16'hA001+2i}, load_req 0->1, sync 5 cycles after WAIT_SYNC -> 24 writes to addrs 32..55 (bank1) with data A000..A017 in order, coef_bank 0->1, load_count 1.
REQ-034 Second load after REQ-033 -> writes to addrs 0..23 (bank0), coef_bank 1->0, load_count 2.
REQ-035 load_req pulse during WR_HI of pair 4 -> load continues unchanged, err_overrun=1; clr_err pulse -> err_overrun=0.
REQ-036 Reset asserted during pair 7 -> coef_we 0 at once, coef_bank 0, load_count 0; no swap after release.
REQ-037 force_swap=1 with no sync_in -> SWAP one cycle after WAIT_SYNC entry; sync_in pulses in IDLE -> no bank change.
REQ-038 load_req held high 100 cycles -> exactly one load, load_count +1, err_overrun stays 0.
